// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: round-robin between instruction-fetch and data ports,
// decoding the granted address onto the BRAM, print and CLINT slaves.
module mem_arbiter #(
  parameter logic [31:0] bram_base_addr  = 32'h0000_0000,
  parameter logic [31:0] bram_top_addr   = 32'h0010_0000,
  parameter logic [31:0] print_base_addr = 32'h0100_0000,
  parameter logic [31:0] print_top_addr  = 32'h0100_0004,
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter logic [31:0] clint_top_addr  = 32'h0200_C000
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,

  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,

  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready,

  output logic        print_valid,
  output logic        print_instr,
  output logic [31:0] print_addr,
  output logic [31:0] print_wdata,
  output logic [3:0]  print_wstrb,
  input  logic [31:0] print_rdata,
  input  logic        print_ready,

  output logic        clint_valid,
  output logic        clint_instr,
  output logic [31:0] clint_addr,
  output logic [31:0] clint_wdata,
  output logic [3:0]  clint_wstrb,
  input  logic [31:0] clint_rdata,
  input  logic        clint_ready
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_ERR} state_t;
  typedef enum logic {PORT_IMEM, PORT_DMEM} port_t;
  typedef enum logic [1:0] {TGT_BRAM, TGT_PRINT, TGT_CLINT, TGT_NONE} target_t;

  state_t      state, state_next;
  port_t       last, grant, grant_next;
  target_t     target, target_next;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] sel_addr;
  logic        any_valid;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
    return (addr >= base) && (addr < top);
  endfunction

  assign any_valid = imem_valid || dmem_valid;

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    grant_next = PORT_DMEM;
    if (imem_valid && dmem_valid)
      grant_next = (last == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
    else if (imem_valid)
      grant_next = PORT_IMEM;

    sel_addr = (grant_next == PORT_IMEM) ? imem_addr : dmem_addr;

    target_next = TGT_NONE;
    if (in_window(sel_addr, bram_base_addr, bram_top_addr))
      target_next = TGT_BRAM;
    else if (grant_next == PORT_DMEM && in_window(sel_addr, print_base_addr, print_top_addr))
      target_next = TGT_PRINT;
    else if (grant_next == PORT_DMEM && in_window(sel_addr, clint_base_addr, clint_top_addr))
      target_next = TGT_CLINT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last      <= PORT_DMEM;
      grant     <= PORT_DMEM;
      target    <= TGT_NONE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else if (state == S_IDLE && any_valid) begin
      last      <= grant_next;
      grant     <= grant_next;
      target    <= target_next;
      req_addr  <= sel_addr;
      req_wdata <= (grant_next == PORT_IMEM) ? '0 : dmem_wdata;
      req_wstrb <= (grant_next == PORT_IMEM) ? '0 : dmem_wstrb;
    end
  end

  always_comb begin
    case (target)
      TGT_BRAM:  begin sel_ready = bram_ready;  sel_rdata = bram_rdata;  end
      TGT_PRINT: begin sel_ready = print_ready; sel_rdata = print_rdata; end
      TGT_CLINT: begin sel_ready = clint_ready; sel_rdata = clint_rdata; end
      default:   begin sel_ready = 1'b0;        sel_rdata = '0;          end
    endcase
  end

  always_comb begin
    state_next  = state;
    imem_rdata  = '0;
    imem_ready  = 1'b0;
    imem_error  = 1'b0;
    dmem_rdata  = '0;
    dmem_ready  = 1'b0;
    dmem_error  = 1'b0;
    bram_valid  = 1'b0;
    bram_instr  = 1'b0;
    bram_addr   = '0;
    bram_wdata  = '0;
    bram_wstrb  = '0;
    print_valid = 1'b0;
    print_instr = 1'b0;
    print_addr  = '0;
    print_wdata = '0;
    print_wstrb = '0;
    clint_valid = 1'b0;
    clint_instr = 1'b0;
    clint_addr  = '0;
    clint_wdata = '0;
    clint_wstrb = '0;

    case (state)
      S_IDLE: begin
        if (any_valid) state_next = S_GRANT;
      end
      S_GRANT: begin
        state_next = S_WAIT;
        case (target)
          TGT_BRAM: begin
            bram_valid = 1'b1;
            bram_instr = (grant == PORT_IMEM);
            bram_addr  = req_addr;
            bram_wdata = req_wdata;
            bram_wstrb = req_wstrb;
          end
          TGT_PRINT: begin
            print_valid = 1'b1;
            print_instr = (grant == PORT_IMEM);
            print_addr  = req_addr;
            print_wdata = req_wdata;
            print_wstrb = req_wstrb;
          end
          TGT_CLINT: begin
            clint_valid = 1'b1;
            clint_instr = (grant == PORT_IMEM);
            clint_addr  = req_addr;
            clint_wdata = req_wdata;
            clint_wstrb = req_wstrb;
          end
          default: state_next = S_ERR;
        endcase
      end
      S_WAIT: begin
        // Completion is passed straight through in the slave's ready cycle.
        if (sel_ready) begin
          state_next = S_IDLE;
          if (grant == PORT_IMEM) begin
            imem_ready = 1'b1;
            imem_rdata = sel_rdata;
          end else begin
            dmem_ready = 1'b1;
            dmem_rdata = sel_rdata;
          end
        end
      end
      S_ERR: begin
        state_next = S_IDLE;
        if (grant == PORT_IMEM) begin
          imem_ready = 1'b1;
          imem_error = 1'b1;
        end else begin
          dmem_ready = 1'b1;
          dmem_error = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-latency slave replies, hand-computed
// expectations checked a fixed number of cycles after each request.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready, imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready, dmem_error;
  logic        bram_valid, bram_instr, bram_ready;
  logic [31:0] bram_addr, bram_wdata, bram_rdata;
  logic [3:0]  bram_wstrb;
  logic        print_valid, print_instr, print_ready;
  logic [31:0] print_addr, print_wdata, print_rdata;
  logic [3:0]  print_wstrb;
  logic        clint_valid, clint_instr, clint_ready;
  logic [31:0] clint_addr, clint_wdata, clint_rdata;
  logic [3:0]  clint_wstrb;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error),
    .bram_valid(bram_valid), .bram_instr(bram_instr), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata),
    .bram_ready(bram_ready),
    .print_valid(print_valid), .print_instr(print_instr), .print_addr(print_addr),
    .print_wdata(print_wdata), .print_wstrb(print_wstrb), .print_rdata(print_rdata),
    .print_ready(print_ready),
    .clint_valid(clint_valid), .clint_instr(clint_instr), .clint_addr(clint_addr),
    .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb), .clint_rdata(clint_rdata),
    .clint_ready(clint_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    imem_valid = 0; imem_addr = '0;
    dmem_valid = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    bram_ready = 0; bram_rdata = '0;
    print_ready = 0; print_rdata = '0;
    clint_ready = 0; clint_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    step();
    step();
    // Reset state
    check("rst_bram_valid", {31'b0, bram_valid}, 32'd0);
    check("rst_imem_ready", {31'b0, imem_ready}, 32'd0);
    check("rst_dmem_ready", {31'b0, dmem_ready}, 32'd0);
    check("rst_bram_addr", bram_addr, 32'd0);
    check("rst_bram_instr", {31'b0, bram_instr}, 32'd0);
    check("rst_dmem_rdata", dmem_rdata, 32'd0);
    reset = 0;
    step();

    // Fetch from BRAM, 1-cycle slave latency
    imem_valid = 1; imem_addr = 32'h0000_0100;
    #1;
    check("f1_idle_bvalid", {31'b0, bram_valid}, 32'd0);
    step();
    check("f1_bvalid", {31'b0, bram_valid}, 32'd1);
    check("f1_binstr", {31'b0, bram_instr}, 32'd1);
    check("f1_baddr", bram_addr, 32'h0000_0100);
    check("f1_bwstrb", {28'b0, bram_wstrb}, 32'd0);
    check("f1_iready_early", {31'b0, imem_ready}, 32'd0);
    step();
    bram_ready = 1; bram_rdata = 32'h0000_0013;
    #1;
    check("f1_iready", {31'b0, imem_ready}, 32'd1);
    check("f1_irdata", imem_rdata, 32'h0000_0013);
    check("f1_ierror", {31'b0, imem_error}, 32'd0);
    check("f1_bvalid_drop", {31'b0, bram_valid}, 32'd0);
    step();
    clear_inputs();
    #1;
    check("f1_iready_drop", {31'b0, imem_ready}, 32'd0);
    check("f1_irdata_zero", imem_rdata, 32'd0);

    // Simultaneous fetch and store: fetch wins the first tie
    reset = 1; #1; reset = 0;
    step();
    imem_valid = 1; imem_addr = 32'h10;
    dmem_valid = 1; dmem_addr = 32'h20; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    step();
    check("t1_binstr", {31'b0, bram_instr}, 32'd1);
    check("t1_baddr", bram_addr, 32'h10);
    step();
    bram_ready = 1; bram_rdata = 32'h1111_2222;
    #1;
    check("t1_iready", {31'b0, imem_ready}, 32'd1);
    check("t1_dready_none", {31'b0, dmem_ready}, 32'd0);
    check("t1_drdata_zero", dmem_rdata, 32'd0);
    step();
    imem_valid = 0; bram_ready = 0; bram_rdata = '0;
    step();
    check("t1s_bvalid", {31'b0, bram_valid}, 32'd1);
    check("t1s_binstr", {31'b0, bram_instr}, 32'd0);
    check("t1s_baddr", bram_addr, 32'h20);
    check("t1s_bwdata", bram_wdata, 32'hDEAD_BEEF);
    check("t1s_bwstrb", {28'b0, bram_wstrb}, 32'hF);
    step();
    bram_ready = 1;
    #1;
    check("t1s_dready", {31'b0, dmem_ready}, 32'd1);
    check("t1s_iready_none", {31'b0, imem_ready}, 32'd0);
    step();
    clear_inputs();
    // Second tie: last grant was data, so fetch wins again
    imem_valid = 1; imem_addr = 32'h10;
    dmem_valid = 1; dmem_addr = 32'h20; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    step();
    check("t2_binstr", {31'b0, bram_instr}, 32'd1);
    check("t2_baddr", bram_addr, 32'h10);
    step();
    bram_ready = 1; bram_rdata = 32'h0000_0077;
    #1;
    check("t2_iready", {31'b0, imem_ready}, 32'd1);
    check("t2_irdata", imem_rdata, 32'h0000_0077);
    step();
    imem_valid = 0; bram_ready = 0;
    step();
    check("t2s_binstr", {31'b0, bram_instr}, 32'd0);
    check("t2s_bvalid", {31'b0, bram_valid}, 32'd1);
    step();
    bram_ready = 1;
    #1;
    check("t2s_dready", {31'b0, dmem_ready}, 32'd1);
    step();
    clear_inputs();

    // Store to print; a stray BRAM ready while waiting must be ignored
    dmem_valid = 1; dmem_addr = 32'h0100_0000; dmem_wdata = 32'h41; dmem_wstrb = 4'h1;
    step();
    check("p_pvalid", {31'b0, print_valid}, 32'd1);
    check("p_bvalid", {31'b0, bram_valid}, 32'd0);
    check("p_cvalid", {31'b0, clint_valid}, 32'd0);
    check("p_pwdata", print_wdata, 32'h41);
    check("p_pwstrb", {28'b0, print_wstrb}, 32'h1);
    step();
    bram_ready = 1;
    #1;
    check("p_stray_ready", {31'b0, dmem_ready}, 32'd0);
    step();
    bram_ready = 0; print_ready = 1;
    #1;
    check("p_dready", {31'b0, dmem_ready}, 32'd1);
    check("p_derror", {31'b0, dmem_error}, 32'd0);
    step();
    clear_inputs();

    // Load from last CLINT word
    dmem_valid = 1; dmem_addr = 32'h0200_BFF8;
    step();
    check("c_cvalid", {31'b0, clint_valid}, 32'd1);
    check("c_caddr", clint_addr, 32'h0200_BFF8);
    check("c_bvalid", {31'b0, bram_valid}, 32'd0);
    step();
    clint_ready = 1; clint_rdata = 32'hCAFE_0001;
    #1;
    check("c_dready", {31'b0, dmem_ready}, 32'd1);
    check("c_drdata", dmem_rdata, 32'hCAFE_0001);
    step();
    clear_inputs();

    // Load one past CLINT top: error two cycles after request
    dmem_valid = 1; dmem_addr = 32'h0200_C000;
    step();
    check("e1_cvalid", {31'b0, clint_valid}, 32'd0);
    check("e1_dready_early", {31'b0, dmem_ready}, 32'd0);
    step();
    check("e1_dready", {31'b0, dmem_ready}, 32'd1);
    check("e1_derror", {31'b0, dmem_error}, 32'd1);
    check("e1_drdata", dmem_rdata, 32'd0);
    step();
    clear_inputs();
    #1;
    check("e1_derror_drop", {31'b0, dmem_error}, 32'd0);

    // Fetch to print window is illegal
    imem_valid = 1; imem_addr = 32'h0100_0000;
    step();
    check("e2_pvalid", {31'b0, print_valid}, 32'd0);
    step();
    check("e2_iready", {31'b0, imem_ready}, 32'd1);
    check("e2_ierror", {31'b0, imem_error}, 32'd1);
    step();
    clear_inputs();

    // Reset during WAIT drops the transaction
    imem_valid = 1; imem_addr = 32'h0000_0200;
    step();
    check("r_bvalid", {31'b0, bram_valid}, 32'd1);
    step();
    reset = 1;
    #1;
    check("r_iready", {31'b0, imem_ready}, 32'd0);
    check("r_bvalid_rst", {31'b0, bram_valid}, 32'd0);
    step();
    reset = 0; imem_valid = 0;
    step();
    bram_ready = 1; bram_rdata = 32'h5555_5555;
    #1;
    check("r_stale_iready", {31'b0, imem_ready}, 32'd0);
    check("r_stale_irdata", imem_rdata, 32'd0);
    step();
    clear_inputs();
    imem_valid = 1; imem_addr = 32'h0000_0300;
    step();
    check("r2_bvalid", {31'b0, bram_valid}, 32'd1);
    check("r2_baddr", bram_addr, 32'h0000_0300);
    step();
    bram_ready = 1; bram_rdata = 32'h0000_0093;
    #1;
    check("r2_iready", {31'b0, imem_ready}, 32'd1);
    check("r2_irdata", imem_rdata, 32'h0000_0093);
    step();
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates between the core's instruction-fetch port and data port for a single shared memory system, and decodes data addresses to the BRAM, print and CLINT slaves. It sits between the fetch/store buffers and the slave devices, serialising all traffic: one transaction is in flight at a time. Fetches are legal only to BRAM; unmapped accesses complete with an error response.

## Interface
- bram_base_addr, 32'h000000, BRAM window start (inclusive)
- bram_top_addr, 32'h100000, BRAM window end (exclusive)
- print_base_addr, 32'h1000000, print window start
- print_top_addr, 32'h1000004, print window end
- clint_base_addr, 32'h2000000, CLINT window start
- clint_top_addr, 32'h200C000, CLINT window end

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_valid / imem_addr[32]  in  fetch request and address; held stable until imem_ready
- imem_rdata  out  32  fetch data, valid with imem_ready
- imem_ready / imem_error  out  1  one-cycle completion / error pulse
- dmem_valid / dmem_addr[32] / dmem_wdata[32] / dmem_wstrb[4]  in  data request; wstrb==0 means read; held until dmem_ready
- dmem_rdata  out  32  load data, valid with dmem_ready
- dmem_ready / dmem_error  out  1  completion / error pulse
- {bram,print,clint}_valid  out  1  one-cycle request pulse to slave
- {bram,print,clint}_instr  out  1  1 = fetch (BRAM only meaningful)
- {bram,print,clint}_addr / _wdata  out  32; _wstrb  out  4
- {bram,print,clint}_rdata  in  32; _ready  in  1  slave completion

## Operation
- FSM: IDLE, GRANT, WAIT, ERR.
- IDLE: if any valid, select winner, latch port id and decode target into registers, go GRANT.
- Arbitration: round-robin via `last` register (reset = data, so fetch wins first tie). Simultaneous requests: grant port not equal to `last`; single request: grant it. `last` updates on each grant.
- Decode: hit = base <= addr < top, unsigned 32-bit compare. Fetch: BRAM hit only, else error. Data: BRAM, print or CLINT; no hit -> error.
- GRANT: pulse selected slave's valid for exactly one cycle with addr/wdata/wstrb/instr from granted port (fetch: wstrb=0, instr=1); go WAIT. Error target -> ERR instead, no slave valid.
- WAIT: when selected slave ready=1, forward its rdata and pulse granted port's ready in same cycle (combinational pass-through); go IDLE. Ready from non-selected slaves ignored.
- ERR: pulse granted port's ready and error, rdata=0; go IDLE.
- A requester's valid is not sampled again until its ready pulse; requester keeps valid asserted only until ready.

## Timing
- Reset: FSM=IDLE, last=data, all valid/ready/error outputs 0, all addr/wdata/wstrb/rdata outputs 0, instr 0. Reset mid-transaction drops it; later stale slave ready ignored in IDLE.
- Request sampled cycle N -> slave valid cycle N+1 -> requester ready in cycle slave ready arrives (>= N+2).
- Error latency: request cycle N -> ready+error cycle N+2.
- Back-to-back: after ready in cycle M, next grant decided in IDLE at M+1, slave valid at M+2. Minimum 3 cycles per transaction with a 1-cycle-latency slave.
- rdata outputs are 0 whenever corresponding ready is 0.
- Slave ready in GRANT cycle (same cycle as valid) is not accepted; slaves respond >=1 cycle after valid.

## Test plan
- Fetch 0x00000100, BRAM ready 1 cycle after valid with 0x00000013 -> bram_valid/instr=1 at N+1, imem_ready with rdata 0x00000013 at N+2, wstrb 0.
- Simultaneous fetch 0x10 and store 0x20 (wdata 0xDEADBEEF, wstrb 0xF) from reset -> fetch served first, store second; next tie after that goes to fetch again (alternation).
- Store 0x1000000 wdata 0x41, wstrb 0x1 -> print_valid pulse only, bram/clint valid stay 0; dmem_ready on print_ready.
- Load 0x200BFF8 -> CLINT selected; load 0x200C000 -> dmem_ready+dmem_error at N+2, rdata 0, no slave valid. Fetch 0x1000000 -> imem_error.
- Assert reset during WAIT, then pulse bram_ready -> all outputs 0, no imem_ready; after release, new request served normally.
